// File: rtl/e_circ_lzf.sv
// e_circ_lzf: registered circular "left-most zero" finder.
// Scans x_i downward from bit pos_i-1, wraps from bit 0 to bit W-1, and ends at bit pos_i.
// The result is given as a one-hot vector, a binary index and a found flag.
// The combinational core is a flat priority search for W<=8.
// For larger W it is a RADIX_N-ary tree. The core result is registered once.
// Optional feature macro: E_CIRC_LZF_ASSERT_EN enables simulation-only checker assertions.

`ifdef E_CIRC_LZF_ASSERT_EN
module e_circ_lzf_chk #(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 out_vld_o,
    input logic [W-1:0]         y_o,
    input logic [$clog2(W)-1:0] y_enc_o,
    input logic                 any_o
);
    if ((RADIX_N < 2) || (RADIX_N > 8) || (W < 2)) begin : g_bad_param
        $error("e_circ_lzf: illegal W/RADIX_N");
    end

    a_onehot : assert property (@(posedge clk) disable iff (rst)
        (out_vld_o && any_o) |-> ($onehot(y_o) && y_o[y_enc_o]));

    a_zero : assert property (@(posedge clk) disable iff (rst)
        (out_vld_o && !any_o) |-> (y_o == '0));
endmodule
`endif

module e_circ_lzf #(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld_i,
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic                 out_vld_o,
    output logic [W-1:0]         y_o,
    output logic [$clog2(W)-1:0] y_enc_o,
    output logic                 any_o
);
    localparam int CW = $clog2(W);

    // Number of tree levels needed so that RADIX_N**levels covers W leaves.
    function automatic int calc_levels(input int width, input int radix);
        int lv;
        longint span;
        lv   = 0;
        span = 64'sd1;
        while (span < longint'(width)) begin
            span = span * longint'(radix);
            lv   = lv + 1;
        end
        return lv;
    endfunction

    localparam int LVL = calc_levels(W, RADIX_N);
    localparam int NP  = RADIX_N ** LVL;

    typedef struct packed {
        logic          found;
        logic [CW-1:0] idx;
    } hit_t;

    // Highest set bit of z, where a set bit marks a free candidate.
    // A flat search is used for narrow vectors. Wider vectors use a tree whose
    // nodes forward the highest child that contains a candidate. Leaves past W
    // are padded as not-free.
    function automatic hit_t find_hi(input logic [W-1:0] z);
        hit_t          res;
        logic          lv_v [0:LVL][0:NP-1];
        logic [CW-1:0] lv_i [0:LVL][0:NP-1];
        int            nodes;
        res = '0;
        for (int l = 0; l <= LVL; l++) begin
            for (int k = 0; k < NP; k++) begin
                lv_v[l][k] = 1'b0;
                lv_i[l][k] = '0;
            end
        end
        if (W <= 8) begin
            for (int i = 0; i < W; i++) begin
                if (z[i]) begin
                    res.found = 1'b1;
                    res.idx   = CW'(i);
                end else begin
                    res = res;
                end
            end
        end else begin
            for (int k = 0; k < W; k++) begin
                lv_v[0][k] = z[k];
                lv_i[0][k] = CW'(k);
            end
            nodes = NP;
            for (int l = 0; l < LVL; l++) begin
                nodes = nodes / RADIX_N;
                for (int j = 0; j < nodes; j++) begin
                    for (int c = 0; c < RADIX_N; c++) begin
                        if (lv_v[l][j*RADIX_N+c]) begin
                            lv_v[l+1][j] = 1'b1;
                            lv_i[l+1][j] = lv_i[l][j*RADIX_N+c];
                        end else begin
                            lv_v[l+1][j] = lv_v[l+1][j];
                        end
                    end
                end
            end
            res.found = lv_v[LVL][0];
            res.idx   = lv_i[LVL][0];
        end
        return res;
    endfunction

    logic          pos_in_s;
    logic [W-1:0]  mask_a_s;
    hit_t          hit_a_s;
    hit_t          hit_b_s;
    hit_t          sel_s;
    logic [W-1:0]  y_nxt_s;

    // Circular search: try free bits below the pointer first, then fall back to all bits.
    // Out-of-range pointers leave mask A empty, which makes them behave like pointer 0.
    always_comb begin
        pos_in_s = ({1'b0, pos_i} < (CW+1)'(W));
        mask_a_s = '0;
        for (int i = 0; i < W; i++) begin
            mask_a_s[i] = pos_in_s && (CW'(i) < pos_i);
        end
        hit_a_s = find_hi(~x_i & mask_a_s);
        hit_b_s = find_hi(~x_i);
        if (hit_a_s.found) begin
            sel_s = hit_a_s;
        end else begin
            sel_s = hit_b_s;
        end
        if (sel_s.found) begin
            y_nxt_s = W'(1) << sel_s.idx;
        end else begin
            y_nxt_s = '0;
        end
    end

    // Output register: capture on valid samples, hold otherwise; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_o <= 1'b0;
            y_o       <= '0;
            y_enc_o   <= '0;
            any_o     <= 1'b0;
        end else if (in_vld_i) begin
            out_vld_o <= 1'b1;
            y_o       <= y_nxt_s;
            y_enc_o   <= sel_s.found ? sel_s.idx : '0;
            any_o     <= sel_s.found;
        end else begin
            out_vld_o <= 1'b0;
        end
    end

`ifdef E_CIRC_LZF_ASSERT_EN
    e_circ_lzf_chk #(.W(W), .RADIX_N(RADIX_N)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_vld_o (out_vld_o),
        .y_o       (y_o),
        .y_enc_o   (y_enc_o),
        .any_o     (any_o)
    );
`endif
endmodule

// File: tb/tb_e_circ_lzf.sv
// Testbench for e_circ_lzf.
// The directed vectors run on a W=16/RADIX_N=4 instance against hand-computed results.
// A random sweep runs over a grid of W and RADIX_N instances, checked against a loop model.
// Expected results go into per-instance queues. Separate monitors pop them on out_vld_o.
module tb_e_circ_lzf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [15:0] x = 16'h0000;
    logic [3:0]  pos = 4'd0;
    logic        out_vld;
    logic [15:0] y;
    logic [3:0]  y_enc;
    logic        any;

    logic        sw_vld = 1'b0;
    logic [63:0] sw_x = 64'd0;
    logic [5:0]  sw_pos = 6'd0;

    int checks = 0;
    int errors = 0;
    event done_ev;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  enc;
        logic        any;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    e_circ_lzf #(.W(16), .RADIX_N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (in_vld),
        .x_i       (x),
        .pos_i     (pos),
        .out_vld_o (out_vld),
        .y_o       (y),
        .y_enc_o   (y_enc),
        .any_o     (any)
    );

    // Monitor for the directed instance.
    always @(negedge clk) begin
        exp_t e;
        if (out_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_valid: out_vld=1 with nothing expected");
            end else begin
                e = exp_q.pop_front();
                if ({y, y_enc, any} !== {e.y, e.enc, e.any}) begin
                    errors++;
                    $display("FAIL main_result: got y=%h enc=%0d any=%b, want y=%h enc=%0d any=%b",
                             y, y_enc, any, e.y, e.enc, e.any);
                end
            end
        end
    end

    // Sweep grid: every W in the list crossed with RADIX_N 2..8.
    localparam int W_LIST [7] = '{2, 5, 8, 9, 16, 33, 64};
    for (genvar a = 0; a < 7; a++) begin : g_w
        for (genvar r = 2; r <= 8; r++) begin : g_r
            localparam int WW  = W_LIST[a];
            localparam int CWW = $clog2(WW);
            logic            ov;
            logic            an;
            logic [WW-1:0]   yy;
            logic [CWW-1:0]  en;
            logic [CWW:0]    q[$];

            e_circ_lzf #(.W(WW), .RADIX_N(r)) u (
                .clk       (clk),
                .rst       (rst),
                .in_vld_i  (sw_vld),
                .x_i       (sw_x[WW-1:0]),
                .pos_i     (sw_pos[CWW-1:0]),
                .out_vld_o (ov),
                .y_o       (yy),
                .y_enc_o   (en),
                .any_o     (an)
            );

            // Behavioural loop model: walk pos-1 down and around, first zero wins.
            function automatic logic [CWW:0] model(input logic [WW-1:0] xv, input logic [CWW-1:0] pv);
                int p;
                int idx;
                logic [CWW:0] res;
                res = '0;
                p = (int'(pv) >= WW) ? 0 : int'(pv);
                for (int k = WW; k >= 1; k--) begin
                    idx = (p - k + WW) % WW;
                    if (!xv[idx]) res = {1'b1, CWW'(idx)};
                end
                return res;
            endfunction

            always @(posedge clk) begin
                if (sw_vld && !rst) q.push_back(model(sw_x[WW-1:0], sw_pos[CWW-1:0]));
            end

            always @(negedge clk) begin
                logic [CWW:0]  e;
                logic [WW-1:0] ye;
                if (ov) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sweep_unexpected_valid W=%0d R=%0d", WW, r);
                    end else begin
                        e  = q.pop_front();
                        ye = e[CWW] ? (WW'(1) << e[CWW-1:0]) : '0;
                        if ({an, en, yy} !== {e, ye}) begin
                            errors++;
                            $display("FAIL sweep_result W=%0d R=%0d: got any=%b enc=%0d y=%h, want any=%b enc=%0d y=%h",
                                     WW, r, an, en, yy, e[CWW], e[CWW-1:0], ye);
                        end
                    end
                end
            end

            always @(done_ev) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL sweep_missing_outputs W=%0d R=%0d: %0d left, want 0", WW, r, q.size());
                end
            end
        end
    end

    logic [15:0] vx   [9];
    logic [3:0]  vp   [9];
    logic [15:0] vy   [9];
    logic [3:0]  ve   [9];
    logic        va   [9];

    task automatic check_idle(input string name, input logic [15:0] ey, input logic [3:0] ee, input logic ea);
        checks++;
        if ({out_vld, y, y_enc, any} !== {1'b0, ey, ee, ea}) begin
            errors++;
            $display("FAIL %s: got vld=%b y=%h enc=%0d any=%b, want vld=0 y=%h enc=%0d any=%b",
                     name, out_vld, y, y_enc, any, ey, ee, ea);
        end
    endtask

    initial begin
        vx[0] = 16'hFFFE; vp[0] = 4'd0;  vy[0] = 16'h0001; ve[0] = 4'd0;  va[0] = 1'b1;
        vx[1] = 16'h0000; vp[1] = 4'd0;  vy[1] = 16'h8000; ve[1] = 4'd15; va[1] = 1'b1;
        vx[2] = 16'h0000; vp[2] = 4'd1;  vy[2] = 16'h0001; ve[2] = 4'd0;  va[2] = 1'b1;
        vx[3] = 16'h0000; vp[3] = 4'd15; vy[3] = 16'h4000; ve[3] = 4'd14; va[3] = 1'b1;
        vx[4] = 16'hFFFF; vp[4] = 4'd0;  vy[4] = 16'h0000; ve[4] = 4'd0;  va[4] = 1'b0;
        vx[5] = 16'hFFFF; vp[5] = 4'd9;  vy[5] = 16'h0000; ve[5] = 4'd0;  va[5] = 1'b0;
        vx[6] = 16'h7FFF; vp[6] = 4'd3;  vy[6] = 16'h8000; ve[6] = 4'd15; va[6] = 1'b1;
        vx[7] = 16'hFFF7; vp[7] = 4'd3;  vy[7] = 16'h0008; ve[7] = 4'd3;  va[7] = 1'b1;
        vx[8] = 16'h2A37; vp[8] = 4'd8;  vy[8] = 16'h0080; ve[8] = 4'd7;  va[8] = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state", 16'h0000, 4'd0, 1'b0);
        rst = 1'b0;

        // Directed vectors back-to-back, one per cycle.
        for (int i = 0; i < 9; i++) begin
            in_vld = 1'b1;
            x      = vx[i];
            pos    = vp[i];
            exp_q.push_back('{y: vy[i], enc: ve[i], any: va[i]});
            @(negedge clk);
        end
        in_vld = 1'b0;
        x      = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        check_idle("hold_after_idle", 16'h0080, 4'd7, 1'b1);

        // Reset wins over a simultaneous valid sample.
        rst    = 1'b1;
        in_vld = 1'b1;
        x      = 16'h0000;
        pos    = 4'd0;
        @(negedge clk);
        check_idle("reset_with_valid", 16'h0000, 4'd0, 1'b0);
        rst    = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        check_idle("after_reset_with_valid", 16'h0000, 4'd0, 1'b0);

        // Random sweep over the parameter grid, with mostly back-to-back valids.
        for (int c = 0; c < 400; c++) begin
            sw_vld = ($urandom_range(3, 0) != 0);
            sw_x   = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) sw_x = ~(64'd1 << $urandom_range(63, 0));
            if ($urandom_range(7, 0) == 0) sw_x = '1;
            sw_pos = 6'($urandom_range(63, 0));
            @(negedge clk);
        end
        sw_vld = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL main_missing_outputs: %0d left, want 0", exp_q.size());
        end
        -> done_ev;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
